imem_loader: RTL and testbench
==============================

# imem_loader

Serial program loader that fills the processor's 4096-word instruction memory over an 8N1 UART line while holding the processor in reset. It is the write side of the instruction-memory port the pipeline only ever reads: it receives a length-prefixed word stream, issues one write strobe per assembled 32-bit word, then releases the core. It sits between the board's RX pin and the imem write port, and drives the processor's `rst`.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); minimum 4.
- `ADDR_WIDTH`, 12, word-address width; capacity = 2^ADDR_WIDTH words.
- `clk`  input  1  system clock.
- `rst`  input  1  reset; one clock; reset is asynchronous and active-high.
- `rxd`  input  1  UART receive line, idle high, asynchronous to `clk`.
- `waddr`  output  ADDR_WIDTH  imem word address of current write.
- `wdata`  output  32  imem write data.
- `we`  output  1  imem write strobe, one cycle per word.
- `cpu_rst`  output  1  processor reset; high until load completes.
- `done`  output  1  sticky; load completed successfully.
- `err`  output  1  sticky; framing, length or checksum error.

## Operation
- `rxd` passes a 2-flop synchronizer; all logic uses the synchronized value.
- Byte receiver FSM: IDLE -> START on synchronized falling edge; START waits CLKS_PER_BIT/2 cycles, returns to IDLE if line is high again (glitch), else -> DATA; DATA samples 8 bits every CLKS_PER_BIT cycles, LSB first; STOP samples once more: high -> byte valid (one-cycle internal strobe), low -> framing error; -> IDLE.
- Byte-to-word assembly: big-endian, first byte into `wdata[31:24]`, fourth into `[7:0]`; byte counter 0..3 wraps.
- Loader FSM: LEN -> PAYLOAD -> (SUM) -> DONE; any error -> ERROR.
  - LEN: first word is word count N. N > 2^ADDR_WIDTH -> ERROR. N = 0 -> next state directly (SUM or DONE).
  - PAYLOAD: each assembled word writes `wdata` at `waddr`, `we` pulses, word index increments; after word N-1 -> next state. Word index never wraps (bounded by N check).
  - DONE: `done`=1, `cpu_rst`=0; further RX bytes ignored.
  - ERROR: `err`=1, `cpu_rst` stays 1; further RX bytes ignored. Exit only via `rst`.
- Framing error in any loader state except DONE -> ERROR.
- `we` is never asserted outside PAYLOAD; `waddr`/`wdata` hold their last values when `we`=0.

## Timing
- Reset values: `cpu_rst`=1, `we`=0, `waddr`=0, `wdata`=0, `done`=0, `err`=0; both FSMs in initial state, counters 0.
- Bit sample point: (CLKS_PER_BIT/2 + k*CLKS_PER_BIT) cycles after synchronized start edge, k=1..9; +2 cycles synchronizer latency from pin.
- `we` rises the cycle after the stop-bit sample of each word's 4th byte; `waddr`/`wdata` valid in that same cycle.
- `cpu_rst` falls and `done` rises the cycle after the last payload write (or after checksum match / LEN with N=0 when applicable).
- `err` rises the cycle after the offending stop-bit sample or offending word.
- `rst` mid-load: all outputs immediately to reset values; partially received byte/word discarded; loader restarts at LEN.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: after the payload one extra word is received in state SUM; it must equal the mod-2^32 sum of all payload words (not N). Match -> DONE; mismatch -> ERROR (`cpu_rst` stays 1; written words remain in imem).
- Undefined: no SUM state; PAYLOAD (or LEN with N=0) goes directly to DONE.

## Test plan
- CLKS_PER_BIT=4, send 00 00 00 02, 12 34 56 78, 9A BC DE F0 -> `we` pulses twice: (0,0x12345678), (1,0x9ABCDEF0); `cpu_rst` falls one cycle after second pulse; `done`=1, `err`=0.
- Send length 00 00 00 00 -> no `we`; `done`=1 after 4th byte (checksum 00000000 required when macro defined).
- Send length 0x00001001 with ADDR_WIDTH=12 -> `err`=1, `cpu_rst`=1, no `we`.
- Byte with stop bit driven low during PAYLOAD -> `err`=1, no further `we` even if valid bytes follow.
- 1-cycle low glitch on idle `rxd` -> no byte accepted; subsequent valid frame loads correctly.
- Checksum build: payload 00000001, 00000002 then checksum 00000004 -> `err`=1, `cpu_rst`=1; with 00000003 -> `done`=1. Assert `rst` mid-byte, resend full frame -> loads from address 0.

Source files
------------

// File: rtl/imem_loader.sv
// UART (8N1) program loader: receives a length-prefixed big-endian word stream, writes it into imem
// and holds the core in reset until done. Define IMEM_LOADER_CHECKSUM_EN to require a trailing sum word.
module imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [31:0]           wdata,
  output logic                  we,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] L_LEN     = 3'd0;
  localparam logic [2:0] L_PAYLOAD = 3'd1;
  localparam logic [2:0] L_DONE    = 3'd3;
  localparam logic [2:0] L_ERROR   = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] L_SUM     = 3'd2;
  localparam logic [2:0] L_AFTER   = L_SUM;
`else
  localparam logic [2:0] L_AFTER   = L_DONE;
`endif

  logic            rx_meta, rx_sync, rx_prev;
  logic [1:0]      rx_state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_byte;
  logic            bit_tick, byte_valid, frame_err;

  logic [2:0]            ld_state;
  logic [1:0]            byte_cnt;
  logic [23:0]           word_sh;
  logic [31:0]           full_word;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   widx;
  logic                  too_big;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]           sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign bit_tick   = (cnt == CW'(CLKS_PER_BIT - 1));
  assign byte_valid = (rx_state == RX_STOP) && bit_tick && rx_sync;
  assign frame_err  = (rx_state == RX_STOP) && bit_tick && !rx_sync;

  // Byte receiver: a start edge is re-checked at mid-bit so single-cycle glitches are rejected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt      <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_tick) begin
            cnt     <= '0;
            rx_byte <= {rx_sync, rx_byte[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (bit_tick) begin
            cnt      <= '0;
            rx_state <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign full_word = {word_sh, rx_byte};
  assign too_big   = ({1'b0, full_word} > (33'd1 << ADDR_WIDTH));

  // Loader: done/cpu_rst follow the state one cycle late so release trails the final write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state <= L_LEN;
      byte_cnt <= '0;
      word_sh  <= '0;
      len      <= '0;
      widx     <= '0;
      waddr    <= '0;
      wdata    <= '0;
      we       <= 1'b0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      we      <= 1'b0;
      done    <= (ld_state == L_DONE);
      cpu_rst <= (ld_state != L_DONE);
      if (ld_state != L_DONE && ld_state != L_ERROR) begin
        if (frame_err) begin
          ld_state <= L_ERROR;
          err      <= 1'b1;
        end else if (byte_valid) begin
          byte_cnt <= byte_cnt + 1'b1;
          word_sh  <= {word_sh[15:0], rx_byte};
          if (byte_cnt == 2'd3) begin
            case (ld_state)
              L_LEN: begin
                if (too_big) begin
                  ld_state <= L_ERROR;
                  err      <= 1'b1;
                end else if (full_word == 32'd0) begin
                  ld_state <= L_AFTER;
                end else begin
                  len      <= full_word[ADDR_WIDTH:0];
                  ld_state <= L_PAYLOAD;
                end
              end
              L_PAYLOAD: begin
                we    <= 1'b1;
                waddr <= widx[ADDR_WIDTH-1:0];
                wdata <= full_word;
                widx  <= widx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum   <= sum + full_word;
`endif
                if (widx + 1'b1 == len) ld_state <= L_AFTER;
              end
`ifdef IMEM_LOADER_CHECKSUM_EN
              L_SUM: begin
                if (full_word == sum) begin
                  ld_state <= L_DONE;
                end else begin
                  ld_state <= L_ERROR;
                  err      <= 1'b1;
                end
              end
`endif
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives UART frames and scoreboards every imem write.
module tb_imem_loader;

  localparam int CPB = 4;
  localparam int AW  = 12;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxd;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          we, cpu_rst, done, err;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_we_cyc = 0;
  int  fall_cyc = 0;
  logic prev_cpu_rst = 1'b1;
  wr_t exp_q[$];

  imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .waddr(waddr), .wdata(wdata),
    .we(we), .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Write monitor: every we pulse must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (we) begin
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_we", 32'(we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("waddr", 32'(waddr), 32'(e.a));
        checkOutput("wdata", wdata, e.d);
      end
    end
    if (prev_cpu_rst && !cpu_rst) fall_cyc = cyc;
    prev_cpu_rst = cpu_rst;
  end

  task automatic sendByte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] w);
    sendByte(w[31:24], 1'b1);
    sendByte(w[23:16], 1'b1);
    sendByte(w[15:8], 1'b1);
    sendByte(w[7:0], 1'b1);
  endtask

  task automatic pushExpect(input logic [AW-1:0] a, input logic [31:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic checkEnd(input string tag, input logic exp_done, input logic exp_err);
    repeat (12) @(negedge clk);
    checkOutput({tag, "_done"}, 32'(done), 32'(exp_done));
    checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
    checkOutput({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
    checkOutput({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_waddr", 32'(waddr), 32'd0);
    checkOutput("rst_wdata", wdata, 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Two-word load
    applyStimulus(32'h0000_0002);
    pushExpect(12'd0, 32'h1234_5678);
    applyStimulus(32'h1234_5678);
    pushExpect(12'd1, 32'h9ABC_DEF0);
    applyStimulus(32'h9ABC_DEF0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(32'hACF1_3568);
`endif
    checkEnd("load2", 1'b1, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    checkOutput("cpu_rst_latency", 32'(fall_cyc - last_we_cyc), 32'd1);
`endif
    checkOutput("waddr_hold", 32'(waddr), 32'd1);
    checkOutput("wdata_hold", wdata, 32'h9ABC_DEF0);
    applyStimulus(32'h1122_3344);
    checkEnd("after_done", 1'b1, 1'b0);

    // Zero-length image
    doReset();
    applyStimulus(32'h0000_0000);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(32'h0000_0000);
`endif
    checkEnd("len0", 1'b1, 1'b0);

    // Length one past capacity
    doReset();
    applyStimulus(32'h0000_1001);
    checkEnd("too_long", 1'b0, 1'b1);

    // Framing error mid-payload, then valid bytes that must be ignored
    doReset();
    applyStimulus(32'h0000_0002);
    pushExpect(12'd0, 32'hDEAD_BEEF);
    applyStimulus(32'hDEAD_BEEF);
    sendByte(8'h55, 1'b0);
    applyStimulus(32'h0102_0304);
    checkEnd("frame_err", 1'b0, 1'b1);

    // Idle-line glitch followed by a good one-word load
    doReset();
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    applyStimulus(32'h0000_0001);
    pushExpect(12'd0, 32'hCAFE_F00D);
    applyStimulus(32'hCAFE_F00D);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(32'hCAFE_F00D);
`endif
    checkEnd("glitch", 1'b1, 1'b0);

    // Reset in the middle of a byte, then a full reload from address 0
    doReset();
    sendByte(8'h00, 1'b1);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    doReset();
    applyStimulus(32'h0000_0001);
    pushExpect(12'd0, 32'h0BAD_F00D);
    applyStimulus(32'h0BAD_F00D);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(32'h0BAD_F00D);
`endif
    checkEnd("midbyte_rst", 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum mismatch and match
    doReset();
    applyStimulus(32'h0000_0002);
    pushExpect(12'd0, 32'h0000_0001);
    applyStimulus(32'h0000_0001);
    pushExpect(12'd1, 32'h0000_0002);
    applyStimulus(32'h0000_0002);
    applyStimulus(32'h0000_0004);
    checkEnd("sum_bad", 1'b0, 1'b1);

    doReset();
    applyStimulus(32'h0000_0002);
    pushExpect(12'd0, 32'h0000_0001);
    applyStimulus(32'h0000_0001);
    pushExpect(12'd1, 32'h0000_0002);
    applyStimulus(32'h0000_0002);
    applyStimulus(32'h0000_0003);
    checkEnd("sum_good", 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
